// File: rtl/ula_arbiter.sv
// Two-requester arbiter in front of a shared combinational ULA, serving one operation at a time.
// Optional macro ULA_ARBITER_RR_EN selects round-robin arbitration; otherwise requester 0 has fixed priority.
module ula_arbiter #(
    parameter int W = 9
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req0_valid,
    input  logic [W-1:0] req0_a,
    input  logic [W-1:0] req0_b,
    input  logic [2:0]   req0_op,
    output logic         req0_ready,
    input  logic         req1_valid,
    input  logic [W-1:0] req1_a,
    input  logic [W-1:0] req1_b,
    input  logic [2:0]   req1_op,
    output logic         req1_ready,
    output logic [W-1:0] SrcA,
    output logic [W-1:0] SrcB,
    output logic [3:0]   ULAControl,
    input  logic [W-1:0] ULAResult,
    input  logic         Z,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic         rsp_id,
    output logic [W-1:0] rsp_result,
    output logic         rsp_z,
    output logic         rsp_err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [W-1:0]   srca_q, srca_d;
    logic [W-1:0]   srcb_q, srcb_d;
    logic [2:0]     ctl_q, ctl_d;
    logic [2:0]     op_q, op_d;
    logic           id_q, id_d;
    logic           rsp_id_q, rsp_id_d;
    logic [W-1:0]   res_q, res_d;
    logic           z_q, z_d;
    logic           err_q, err_d;

    logic           any_req;
    logic           gnt_id;
    logic [2:0]     gnt_op;
    logic           gnt_illegal;
    logic           op_illegal;

    assign any_req = req0_valid | req1_valid;

`ifdef ULA_ARBITER_RR_EN
    logic ptr_q, ptr_d;

    // On a tie the pointed requester wins; a lone requester always wins.
    assign gnt_id = (req0_valid && req1_valid) ? ptr_q : req1_valid;

    always_comb begin
        ptr_d = ptr_q;
        if (state_q == S_IDLE && any_req) begin
            ptr_d = ~gnt_id;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`else
    assign gnt_id = ~req0_valid;
`endif

    assign gnt_op      = gnt_id ? req1_op : req0_op;
    assign gnt_illegal = (gnt_op[2:1] == 2'b10);
    assign op_illegal  = (op_q[2:1] == 2'b10);

    always_comb begin
        state_d    = state_q;
        srca_d     = srca_q;
        srcb_d     = srcb_q;
        ctl_d      = ctl_q;
        op_d       = op_q;
        id_d       = id_q;
        rsp_id_d   = rsp_id_q;
        res_d      = res_q;
        z_d        = z_q;
        err_d      = err_q;
        req0_ready = 1'b0;
        req1_ready = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (any_req && rst_n) begin
                    req0_ready = ~gnt_id;
                    req1_ready = gnt_id;
                    op_d       = gnt_op;
                    id_d       = gnt_id;
                    // An illegal op never reaches the ULA, so its drive keeps the previous operation.
                    if (!gnt_illegal) begin
                        srca_d = gnt_id ? req1_a : req0_a;
                        srcb_d = gnt_id ? req1_b : req0_b;
                        ctl_d  = gnt_op;
                    end
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                rsp_id_d = id_q;
                if (op_illegal) begin
                    res_d = '0;
                    z_d   = 1'b1;
                    err_d = 1'b1;
                end else begin
                    res_d = ULAResult;
                    z_d   = Z;
                    err_d = 1'b0;
                end
                state_d = S_RESP;
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            srca_q   <= '0;
            srcb_q   <= '0;
            ctl_q    <= '0;
            op_q     <= '0;
            id_q     <= 1'b0;
            rsp_id_q <= 1'b0;
            res_q    <= '0;
            z_q      <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            srca_q   <= srca_d;
            srcb_q   <= srcb_d;
            ctl_q    <= ctl_d;
            op_q     <= op_d;
            id_q     <= id_d;
            rsp_id_q <= rsp_id_d;
            res_q    <= res_d;
            z_q      <= z_d;
            err_q    <= err_d;
        end
    end

    assign SrcA       = srca_q;
    assign SrcB       = srcb_q;
    assign ULAControl = {1'b0, ctl_q};
    assign rsp_valid  = (state_q == S_RESP);
    assign rsp_id     = rsp_id_q;
    assign rsp_result = res_q;
    assign rsp_z      = z_q;
    assign rsp_err    = err_q;

endmodule

// File: doc/ula_arbiter.md
ULA_ARBITER -- requirements
Module: ula_arbiter

Interface
REQ-001 Parameter W, default 9, operand/result width, matching the shared ULA datapath.
REQ-002 clk  input  1  rising-edge clock; the only clock.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 req0_valid / req1_valid  input  1  requester k has an operation pending.
REQ-005 req0_a, req0_b / req1_a, req1_b  input  W  operands of requester k.
REQ-006 req0_op / req1_op  input  3  operation code (000 AND, 001 OR, 010 ADD, 011 NOR, 110 SUB, 111 SLT).
REQ-007 req0_ready / req1_ready  output  1  acceptance strobe for requester k.
REQ-008 SrcA, SrcB  output  W  operands driven to the shared ULA.
REQ-009 ULAControl  output  4  opcode driven to the ULA; bit 3 always 0.
REQ-010 ULAResult  input  W; Z  input  1  ULA combinational result and zero flag.
REQ-011 rsp_valid  output  1; rsp_ready  input  1  response handshake.
REQ-012 rsp_id  output  1  index of the requester the response belongs to.
REQ-013 rsp_result  output  W; rsp_z  output  1; rsp_err  output  1  captured result, zero flag, illegal-op flag.

Function
REQ-014 FSM states: IDLE, EXEC, RESP; the block serves exactly one operation at a time.
REQ-015 IDLE: if any reqk_valid, grant one, assert only that reqk_ready combinationally in the same cycle, latch its a/b/op/id, go to EXEC.
REQ-016 reqk_ready is 0 in EXEC and RESP, and 0 for every non-granted requester.
REQ-017 Arbitration: see REQ-027/028; a single valid requester is always granted.
REQ-018 EXEC (one cycle): SrcA/SrcB/ULAControl driven from the latched registers; at the clock edge ending EXEC, capture ULAResult into rsp_result and Z into rsp_z; go to RESP.
REQ-019 Outside EXEC, SrcA, SrcB and ULAControl hold their last driven values (no glitching to the ULA).
REQ-020 Illegal op (100, 101): ULA not used (ULAControl holds previous value); EXEC still takes one cycle; response has rsp_result 0, rsp_z 1, rsp_err 1.
REQ-021 Legal op: rsp_err 0.
REQ-022 RESP: rsp_valid 1 with rsp_id/rsp_result/rsp_z/rsp_err stable until rsp_valid & rsp_ready; then return to IDLE.
REQ-023 Latency: accept at edge N, EXEC during cycle N+1, rsp_valid asserted in cycle N+2; with rsp_ready held 1, a new acceptance occurs no earlier than cycle N+3 (throughput one op per 3 cycles).
REQ-024 Arithmetic is W-bit modulo 2^W; carries/borrows discarded; SLT is unsigned (result 1 or 0, zero-extended).
REQ-025 Requesters must hold their inputs stable while valid until ready; dropping valid before ready is legal and cancels the request.

Reset
REQ-026 rst_n low at a clock edge: FSM to IDLE, rsp_valid 0, rsp_id 0, rsp_result 0, rsp_z 0, rsp_err 0, SrcA 0, SrcB 0, ULAControl 0, priority pointer to requester 0; any in-flight operation is discarded with no response; req0_ready/req1_ready are 0 while rst_n is low.

Configuration
REQ-027 Macro ULA_ARBITER_RR_EN defined: round-robin; a 1-bit pointer marks the preferred requester, updated on each grant to the non-granted index; on simultaneous requests the pointed requester wins.
REQ-028 ULA_ARBITER_RR_EN undefined: fixed priority, requester 0 always wins on simultaneous requests; pointer logic absent.

Verification
REQ-029 req0 ADD a=9'h0FF b=9'h001, rsp_ready=1 -> rsp_valid 2 cycles after accept, rsp_id 0, rsp_result 9'h100, rsp_z 0, rsp_err 0.
REQ-030 req1 SUB a=5 b=5 -> rsp_result 0, rsp_z 1, rsp_id 1; SUB a=0 b=1 -> rsp_result 9'h1FF.
REQ-031 Both valid every cycle, 4 ops each -> RR_EN defined: grants alternate 0,1,0,1...; undefined: all req0 ops first, req1 starved while req0 valid.
REQ-032 req0 op=101 -> rsp_err 1, rsp_result 0, rsp_z 1; ULAControl unchanged from previous op.
REQ-033 rsp_ready held 0 for 5 cycles in RESP -> rsp fields stable, req0_ready/req1_ready 0 throughout; completes on first cycle rsp_ready=1.
REQ-034 rst_n low during EXEC -> next cycle IDLE, rsp_valid 0, all outputs at reset values, no response for the dropped op.
